// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares one LC-3 memory port between two masters,
// round-robin or fixed priority, with a wait-cycle timeout that aborts stuck accesses.
module lc3_mem_arbiter #(
  parameter int TIMEOUT    = 64,
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_en,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_din,
  output logic [15:0] m0_dout,
  output logic        m0_rdy,
  output logic        m0_err,
  input  logic        m1_en,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_din,
  output logic [15:0] m1_dout,
  output logic        m1_rdy,
  output logic        m1_err,
  output logic        memEN,
  output logic        memWE,
  output logic [15:0] memory_addr,
  output logic [15:0] memory_din,
  input  logic [15:0] memory_dout,
  input  logic        memRDY,
  output logic [1:0]  gnt
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT - 1);
  state_t     state, state_nx;
  logic       last_gnt;
  logic [7:0] wait_cnt;
  logic       expired, own0, own1;
  assign expired = wait_cnt == WAIT_MAX;
  // last_gnt resets to 1 so that m0 wins the first tie
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      wait_cnt <= 8'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx != IDLE) last_gnt <= state_nx == GRANT1;
      wait_cnt <= state == IDLE ? 8'd0 : memRDY ? wait_cnt : wait_cnt + 8'd1;
    end
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = m0_en && (!m1_en || FIXED_PRIO != 0 || last_gnt) ? GRANT0 : m1_en ? GRANT1 : IDLE;
    else if (memRDY || expired)
      state_nx = IDLE;
  end
  // rst gates the outputs so nothing leaks out while reset is held
  always_comb begin
    own0        = rst && state == GRANT0;
    own1        = rst && state == GRANT1;
    memEN       = own0 || own1;
    gnt         = {own1, own0};
    memWE       = own0 ? m0_we : own1 && m1_we;
    memory_addr = own0 ? m0_addr : own1 ? m1_addr : 16'h0000;
    memory_din  = own0 ? m0_din : own1 ? m1_din : 16'h0000;
    m0_rdy      = own0 && (memRDY || expired);
    m0_err      = own0 && !memRDY && expired;
    m0_dout     = own0 && memRDY && !m0_we ? memory_dout : 16'h0000;
    m1_rdy      = own1 && (memRDY || expired);
    m1_err      = own1 && !memRDY && expired;
    m1_dout     = own1 && memRDY && !m1_we ? memory_dout : 16'h0000;
  end
endmodule
